nco_phase_fold: RTL and testbench
=================================

# nco_phase_fold

Numerically controlled phase generator that feeds the CORDIC sine/cosine stage. It accumulates a frequency tuning word once per sample strobe and adds a phase offset. It folds the phase into the CORDIC convergence range [-π/2, +π/2] and emits a signed angle with a valid pulse. A cos-negate flag travels alongside, delayed to line up with the CORDIC outputs, so the consumer can restore the sign of cosine.

## Interface
- ACC_WIDTH, 32: phase accumulator width; must be ≥ WIDTH+16.
- WIDTH, 16: angle width; signed, full scale ±2^(WIDTH-1) = ±π (π/4 = 8192 at WIDTH=16).
- ITER, 15: CORDIC iteration count; the flag delay line is ITER+1 deep.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ftw_i  in  ACC_WIDTH  frequency tuning word, unsigned.
- pof_i  in  WIDTH  phase offset, signed.
- cfg_load_i  in  1  captures ftw_i/pof_i into the shadow registers.
- sample_en_i  in  1  produces one phase sample and advances the accumulator.
- sync_clr_i  in  1  synchronous accumulator clear.
- angle_o  out  WIDTH  signed folded angle; drives CORDIC angle.
- valid_o  out  1  one-cycle pulse per sample; drives CORDIC valid_i.
- cos_neg_o  out  1  fold flag, aligned with angle_o.
- cos_neg_d_o  out  1  cos_neg_o delayed ITER+1 cycles; aligned with the CORDIC valid_o.

## Operation
- Registers: acc, ftw_act, pof_act, ftw_sh, pof_sh, pend, delay line, and (with dither) a 16-bit LFSR.
- **Config load**
  - cfg_load_i=1: ftw_sh←ftw_i, pof_sh←pof_i, pend←1.
  - On the next sample_en_i with pend=1: that sample uses the shadow values, the shadow values are copied to the active registers, and pend←0.
  - cfg_load_i and sample_en_i in the same cycle: the sample uses the previous values; the new values apply from the following sample.
- **Sample**, on sample_en_i:
  - a = (sync_clr_i ? 0 : acc).
  - p = a[ACC_WIDTH-1 -: WIDTH] + pof, modulo 2^WIDTH, as a signed value.
  - acc ← a + ftw, wrapping modulo 2^ACC_WIDTH.
- sync_clr_i without sample_en_i: acc←0 and no output.
- **Fold**, computed in WIDTH+1 bits with the result fitting in WIDTH bits (H = 2^(WIDTH-2)):
  - p > H: angle = 2^(WIDTH-1) − p, cos_neg=1.
  - p < −H: angle = −2^(WIDTH-1) − p, cos_neg=1.
  - p = −2^(WIDTH-1): angle = 0, cos_neg=1.
  - Otherwise, including p = ±H: angle = p, cos_neg=0.
- sin is preserved by the fold; the consumer negates cos when cos_neg_d_o=1.
- **Delay line**: ITER+1-stage shift register that shifts every cycle, input is cos_neg_o. This matches the free-running CORDIC pipeline.
- **Reset**:
  - acc, ftw_act, pof_act, ftw_sh, pof_sh, pend, and all delay stages clear to 0.
  - angle_o=0, valid_o=0, cos_neg_o=0, cos_neg_d_o=0.
  - LFSR loads 16'hACE1.
  - Asserting reset mid-run discards samples in flight.

## Timing
- sample_en_i at edge n → angle_o, cos_neg_o, valid_o registered at n+1.
- valid_o is high for exactly one cycle per strobe; sample_en_i may be asserted every cycle.
- Between strobes, angle_o and cos_neg_o hold their last values and valid_o=0.
- cos_neg_d_o at cycle n+1+ITER+1 equals cos_neg_o at n+1 (n+17 at defaults). This matches the CORDIC valid_o latency of ITER+1.
- No backpressure: the downstream stage always accepts.

## Configuration
- NCO_DITHER_EN defined:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - Advances once per sample_en_i.
  - The LFSR is added into acc bits [ACC_WIDTH-WIDTH-1 -: 16] before truncation, affecting p only; acc itself is unchanged.
- NCO_DITHER_EN undefined:
  - Plain truncation, and no LFSR is instantiated.
  - Outputs are bit-exact with the fold rule above.
  - All directed tests below assume this mode.

## Test plan
- **Reset:** assert rst mid-stream → all outputs 0 in the same cycle; after release, the first sample with ftw=0, pof=0 → angle_o=0, cos_neg_o=0.
- **Quarter-turn sweep:** ftw=0x40000000, pof=0, cfg_load then 4 strobes → angle_o = 0, 16384, 0, −16384; cos_neg_o = 0, 0, 1, 0.
- **Fold:**
  - ftw=0, pof=0x6000 → angle_o=8192, cos_neg_o=1.
  - pof=0xA000 → angle_o=−8192, cos_neg_o=1.
  - pof=0x4000 → 16384, cos_neg_o=0.
- **Simultaneous load/sample:** ftw=0x40000000 active; cfg_load_i with ftw=0 in the same cycle as sample_en_i → that sample and the next both advance by 0x40000000, and later samples hold constant.
- **sync_clr:** after 3 quarter-turn samples, sync_clr_i+sample_en_i → angle_o=0, and the next sample gives 16384.
- **Alignment:** single cos_neg_o=1 pulse → cos_neg_d_o=1 exactly ITER+1=16 cycles later; rst during the delay → cos_neg_d_o never rises.

Source files
------------

// File: rtl/nco_phase_fold_if.sv
// Configuration and sample-output bundle for nco_phase_fold.
// The DUT uses the slave modport; a driver of the NCO uses the master modport.
interface nco_phase_fold_if #(
    parameter int ACC_WIDTH = 32,
    parameter int WIDTH     = 16
);
    logic        [ACC_WIDTH-1:0] ftw_i;
    logic signed [WIDTH-1:0]     pof_i;
    logic                        cfg_load_i;
    logic                        sample_en_i;
    logic                        sync_clr_i;
    logic signed [WIDTH-1:0]     angle_o;
    logic                        valid_o;
    logic                        cos_neg_o;
    logic                        cos_neg_d_o;

    modport slave (
        input  ftw_i, pof_i, cfg_load_i, sample_en_i, sync_clr_i,
        output angle_o, valid_o, cos_neg_o, cos_neg_d_o
    );

    modport master (
        output ftw_i, pof_i, cfg_load_i, sample_en_i, sync_clr_i,
        input  angle_o, valid_o, cos_neg_o, cos_neg_d_o
    );
endinterface

// File: rtl/nco_phase_fold.sv
// Phase accumulator + offset, folded into [-pi/2, +pi/2] for a CORDIC stage, with a cos-negate flag.
// Optional NCO_DITHER_EN adds a 16-bit LFSR below the truncation point of the phase.
module nco_phase_fold #(
    parameter int ACC_WIDTH = 32,
    parameter int WIDTH     = 16,
    parameter int ITER      = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    nco_phase_fold_if.slave        bus
);
    localparam int                 PI_I   = 2 ** (WIDTH - 1);
    localparam int                 NPI_I  = -(2 ** (WIDTH - 1));
    localparam int                 QTR_I  = 2 ** (WIDTH - 2);
    localparam int                 NQTR_I = -(2 ** (WIDTH - 2));
    localparam logic signed [WIDTH:0] PI   = PI_I[WIDTH:0];
    localparam logic signed [WIDTH:0] NPI  = NPI_I[WIDTH:0];
    localparam logic signed [WIDTH:0] QTR  = QTR_I[WIDTH:0];
    localparam logic signed [WIDTH:0] NQTR = NQTR_I[WIDTH:0];

    logic        [ACC_WIDTH-1:0] acc_q, acc_d, ftw_act_q, ftw_sh_q, ftw_eff, a_base, a_phase;
    logic signed [WIDTH-1:0]     pof_act_q, pof_sh_q, pof_eff, p_d;
    logic signed [WIDTH-1:0]     angle_q, angle_d;
    logic signed [WIDTH:0]       pe, fold;
    logic                        pend_q, pend_d, valid_q, cos_neg_q, cos_neg_d;
    logic        [ITER:0]        neg_pipe_q;

`ifdef NCO_DITHER_EN
    localparam int SHAMT = ACC_WIDTH - WIDTH - 16;
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign a_phase = a_base + ({{(ACC_WIDTH-16){1'b0}}, lfsr_q} << SHAMT);
`else
    assign a_phase = a_base;
`endif

    always_comb begin
        // A pending shadow load applies to the very next sample.
        ftw_eff = pend_q ? ftw_sh_q : ftw_act_q;
        pof_eff = pend_q ? pof_sh_q : pof_act_q;
        a_base  = bus.sync_clr_i ? '0 : acc_q;
        acc_d   = a_base + ftw_eff;
        p_d     = a_phase[ACC_WIDTH-1 -: WIDTH] + pof_eff;
        pe      = {p_d[WIDTH-1], p_d};
        fold    = pe;
        cos_neg_d = 1'b0;
        // p = -pi lands in the second branch and folds to 0 with the flag set.
        if (pe > QTR) begin
            fold      = PI - pe;
            cos_neg_d = 1'b1;
        end else if (pe < NQTR) begin
            fold      = NPI - pe;
            cos_neg_d = 1'b1;
        end
        angle_d = fold[WIDTH-1:0];
        pend_d  = bus.cfg_load_i ? 1'b1 : (bus.sample_en_i ? 1'b0 : pend_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            ftw_act_q  <= '0;
            pof_act_q  <= '0;
            ftw_sh_q   <= '0;
            pof_sh_q   <= '0;
            pend_q     <= 1'b0;
            angle_q    <= '0;
            valid_q    <= 1'b0;
            cos_neg_q  <= 1'b0;
            neg_pipe_q <= '0;
`ifdef NCO_DITHER_EN
            lfsr_q     <= 16'hACE1;
`endif
        end else begin
            pend_q     <= pend_d;
            valid_q    <= bus.sample_en_i;
            neg_pipe_q <= {neg_pipe_q[ITER-1:0], cos_neg_q};
            if (bus.cfg_load_i) begin
                ftw_sh_q <= bus.ftw_i;
                pof_sh_q <= bus.pof_i;
            end
            if (bus.sample_en_i) begin
                acc_q     <= acc_d;
                angle_q   <= angle_d;
                cos_neg_q <= cos_neg_d;
                if (pend_q) begin
                    ftw_act_q <= ftw_sh_q;
                    pof_act_q <= pof_sh_q;
                end
`ifdef NCO_DITHER_EN
                lfsr_q <= lfsr_d;
`endif
            end else if (bus.sync_clr_i) begin
                acc_q <= '0;
            end
        end
    end

    assign bus.angle_o     = angle_q;
    assign bus.valid_o     = valid_q;
    assign bus.cos_neg_o   = cos_neg_q;
    assign bus.cos_neg_d_o = neg_pipe_q[ITER];
endmodule

// File: tb/tb_nco_phase_fold.sv
// Bench for nco_phase_fold: integer phase model + directed literal cases + random config/strobe traffic.
module tb_nco_phase_fold;
    localparam int ACC_W = 32;
    localparam int W     = 16;
    localparam int IT    = 15;
    localparam logic [ACC_W-1:0] QTURN = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    nco_phase_fold_if #(.ACC_WIDTH(ACC_W), .WIDTH(W)) bus();
    nco_phase_fold #(.ACC_WIDTH(ACC_W), .WIDTH(W), .ITER(IT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: integer phase arithmetic and a history queue for the delayed flag.
    logic [ACC_W-1:0] m_acc, m_ftw, sh_ftw;
    logic [W-1:0]     m_pof, sh_pof;
    bit               m_pend;
    int               e_ang;
    bit               e_neg, e_vld, e_d;
    bit               hist[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc = '0; m_ftw = '0; sh_ftw = '0; m_pof = '0; sh_pof = '0; m_pend = 0;
            e_ang = 0; e_neg = 0; e_vld = 0; e_d = 0;
            hist.delete();
        end else begin
            logic [ACC_W-1:0] f, a;
            logic [W-1:0]     pf;
            int               pu, p;
            hist.push_back(e_neg);
            if (hist.size() > IT + 1) void'(hist.pop_front());
            e_d = (hist.size() == IT + 1) ? hist[0] : 1'b0;
            if (bus.sample_en_i) begin
                f  = m_pend ? sh_ftw : m_ftw;
                pf = m_pend ? sh_pof : m_pof;
                a  = bus.sync_clr_i ? '0 : m_acc;
                pu = (int'(a >> (ACC_W - W)) + int'(pf)) % (2 ** W);
                p  = (pu >= 2 ** (W - 1)) ? pu - 2 ** W : pu;
                if (p > 2 ** (W - 2))       begin e_ang = 2 ** (W - 1) - p;    e_neg = 1; end
                else if (p < -(2 ** (W - 2))) begin e_ang = -(2 ** (W - 1)) - p; e_neg = 1; end
                else                        begin e_ang = p;                   e_neg = 0; end
                e_vld = 1;
                m_acc = a + f;
                if (m_pend) begin m_ftw = sh_ftw; m_pof = sh_pof; m_pend = 0; end
            end else begin
                e_vld = 0;
                if (bus.sync_clr_i) m_acc = '0;
            end
            if (bus.cfg_load_i) begin sh_ftw = bus.ftw_i; sh_pof = bus.pof_i; m_pend = 1; end
        end
    end

    always @(negedge clk) begin
        checks += 4;
        if (int'(bus.angle_o) != e_ang) begin
            failures++; $display("FAIL model_angle t=%0t got=%0d exp=%0d", $time, bus.angle_o, e_ang);
        end
        if (bus.cos_neg_o !== e_neg) begin
            failures++; $display("FAIL model_cos_neg t=%0t got=%0b exp=%0b", $time, bus.cos_neg_o, e_neg);
        end
        if (bus.valid_o !== e_vld) begin
            failures++; $display("FAIL model_valid t=%0t got=%0b exp=%0b", $time, bus.valid_o, e_vld);
        end
        if (bus.cos_neg_d_o !== e_d) begin
            failures++; $display("FAIL model_cos_neg_d t=%0t got=%0b exp=%0b", $time, bus.cos_neg_d_o, e_d);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the active edge.
    task automatic step(input bit se, input bit ld, input bit clr,
                        input logic [ACC_W-1:0] f, input logic [W-1:0] po);
        bus.sample_en_i = se; bus.cfg_load_i = ld; bus.sync_clr_i = clr;
        bus.ftw_i = f; bus.pof_i = po;
        @(posedge clk); #1;
        bus.sample_en_i = 0; bus.cfg_load_i = 0; bus.sync_clr_i = 0;
    endtask

    task automatic chk_out(input string nm, input int ang, input int neg);
        chk({nm, "_angle"}, int'(bus.angle_o), ang);
        chk({nm, "_cos_neg"}, int'(bus.cos_neg_o), neg);
        chk({nm, "_valid"}, int'(bus.valid_o), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int rise, highs;
        bus.ftw_i = '0; bus.pof_i = '0;
        bus.cfg_load_i = 0; bus.sample_en_i = 0; bus.sync_clr_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_angle", int'(bus.angle_o), 0);
        chk("reset_valid", int'(bus.valid_o), 0);
        rst = 0;
        step(1, 0, 0, '0, '0);
        chk_out("first", 0, 0);
        step(0, 0, 0, '0, '0);
        chk("idle_valid", int'(bus.valid_o), 0);

        // Quarter-turn sweep
        step(0, 1, 0, QTURN, '0);
        step(1, 0, 0, '0, '0); chk_out("qt0", 0, 0);
        step(1, 0, 0, '0, '0); chk_out("qt1", 16384, 0);
        step(1, 0, 0, '0, '0); chk_out("qt2", 0, 1);
        step(1, 0, 0, '0, '0); chk_out("qt3", -16384, 0);

        // Fold edges (acc returned to 0 after four quarter turns)
        step(0, 1, 0, '0, 16'h6000); step(1, 0, 0, '0, '0); chk_out("fold6000", 8192, 1);
        step(0, 1, 0, '0, 16'hA000); step(1, 0, 0, '0, '0); chk_out("foldA000", -8192, 1);
        step(0, 1, 0, '0, 16'h4000); step(1, 0, 0, '0, '0); chk_out("fold4000", 16384, 0);

        // Load coinciding with a sample
        step(0, 1, 0, QTURN, '0);
        step(1, 0, 0, '0, '0); chk_out("sim0", 0, 0);
        step(1, 1, 0, '0, '0); chk_out("sim1", 16384, 0);
        step(1, 0, 0, '0, '0); chk_out("sim2", 0, 1);
        step(1, 0, 0, '0, '0); chk_out("sim3", 0, 1);

        // sync_clr
        step(0, 1, 1, QTURN, '0);
        step(1, 0, 0, '0, '0); step(1, 0, 0, '0, '0); step(1, 0, 0, '0, '0);
        chk_out("pre_clr", 0, 1);
        step(1, 0, 1, '0, '0); chk_out("clr", 0, 0);
        step(1, 0, 0, '0, '0); chk_out("post_clr", 16384, 0);

        // Reset mid-run clears outputs immediately
        rst = 1; #1;
        chk("rst_angle", int'(bus.angle_o), 0);
        chk("rst_valid", int'(bus.valid_o), 0);
        @(posedge clk); #1; rst = 0;
        step(1, 0, 0, '0, '0); chk_out("after_rst", 0, 0);

        // Flag alignment through the delay line
        step(0, 1, 0, '0, 16'h6000);
        step(1, 1, 0, '0, '0); chk_out("pulse", 8192, 1);
        rise = -1;
        for (int k = 1; k <= IT + 4; k++) begin
            step(k == 1, 0, 0, '0, '0);
            if (bus.cos_neg_d_o && rise < 0) rise = k;
        end
        chk("align_latency", rise, IT + 1);

        // Reset during the delay flushes the flag
        step(0, 1, 0, '0, 16'h6000);
        step(1, 1, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        repeat (4) step(0, 0, 0, '0, '0);
        rst = 1;
        repeat (2) step(0, 0, 0, '0, '0);
        rst = 0;
        highs = 0;
        for (int k = 0; k < IT + 4; k++) begin
            step(0, 0, 0, '0, '0);
            if (bus.cos_neg_d_o) highs++;
        end
        chk("rst_flush", highs, 0);

        // Random traffic checked by the model
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                rst = 1; step(0, 0, 0, '0, '0); rst = 0;
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom, W'($urandom));
        end
        repeat (IT + 3) step(0, 0, 0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
